// File: rtl/trans_pipe_stage_pkg.sv
// Shared payload layout for every pipeline-boundary instance, so each stage
// packs and unpacks the instr/op/operands/writeback fields identically.
package trans_pipe_stage_pkg;

   localparam int INSTR_W = 32;
   localparam int OP_W    = 8;
   localparam int OPND_W  = 32;
   localparam int WE_W    = 1;
   localparam int WADDR_W = 5;
   localparam int WDATA_W = 32;

   localparam int DEFAULT_PAYLOAD_W = INSTR_W + OP_W + 2 * OPND_W + WE_W + WADDR_W + WDATA_W;

   localparam logic [OP_W-1:0] OP_NOP = '0;

   // Field order is MSB-first: instr sits in the top bits of the payload bus.
   typedef struct packed {
      logic [INSTR_W-1:0] instr;
      logic [OP_W-1:0]    op;
      logic [OPND_W-1:0]  op_a;
      logic [OPND_W-1:0]  op_b;
      logic [WE_W-1:0]    we;
      logic [WADDR_W-1:0] waddr;
      logic [WDATA_W-1:0] wdata;
   } payload_t;

   localparam payload_t NOP_DEFAULT = '{
      instr: '0,
      op:    OP_NOP,
      op_a:  '0,
      op_b:  '0,
      we:    '0,
      waddr: '0,
      wdata: '0
   };

endpackage

// File: rtl/trans_pipe_stage_if.sv
// Valid/ready payload channel used on both sides of a pipeline stage.
interface trans_pipe_stage_if
   import trans_pipe_stage_pkg::*;
#(
   parameter int W = DEFAULT_PAYLOAD_W
) ();

   // A beat transfers on a clock edge where valid and ready are both 1.
   // While valid=1 and ready=0 the master holds payload stable; valid must
   // never depend combinationally on ready.
   logic         valid;
   logic         ready;
   logic [W-1:0] payload;

   modport master (output valid, output payload, input ready);
   modport slave  (input valid, input payload, output ready);

endinterface

// File: rtl/trans_pipe_stage_buf.sv
// Circular-buffer storage: one synchronous write port, one asynchronous read port.
module trans_pipe_stage_buf #(
   parameter int WIDTH  = 142,
   parameter int DEPTH  = 2,
   parameter int ADDR_W = 1
) (
   input  logic              clock,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [WIDTH-1:0]  wdata,
   input  logic [ADDR_W-1:0] raddr,
   output logic [WIDTH-1:0]  rdata
);

   // Storage is deliberately not reset; the control logic masks it via count.
   logic [WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clock) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/trans_pipe_stage.sv
// Elastic pipeline stage: DEPTH-entry circular buffer between two valid/ready
// channels, with flush and bubble (NOP) insertion when empty.
module trans_pipe_stage
   import trans_pipe_stage_pkg::*;
#(
   parameter int                   PAYLOAD_W   = DEFAULT_PAYLOAD_W,
   parameter int                   DEPTH       = 2,
   parameter int                   PIPE_READY  = 1,
   parameter logic [PAYLOAD_W-1:0] NOP_PAYLOAD = PAYLOAD_W'(NOP_DEFAULT)
) (
   input  logic                         clock,
   input  logic                         reset,
   input  logic                         flush,
   trans_pipe_stage_if.slave            in_if,
   trans_pipe_stage_if.master           out_if,
   output logic [$clog2(DEPTH+1)-1:0]   occupancy
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = $clog2(DEPTH + 1);
   localparam logic [PTR_W-1:0] LAST_PTR  = PTR_W'(DEPTH - 1);
   localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);
   localparam logic             PIPE_EN   = (PIPE_READY != 0);

   logic [PTR_W-1:0]     rd_ptr;
   logic [PTR_W-1:0]     wr_ptr;
   logic [CNT_W-1:0]     count;
   logic                 full;
   logic                 push;
   logic                 pop;
   logic [PAYLOAD_W-1:0] head;

   assign full         = (count == DEPTH_CNT);
   // When full, a same-cycle pop frees the slot the push lands in.
   assign in_if.ready  = !reset && !flush && (!full || (PIPE_EN && out_if.ready));
   assign out_if.valid = (count != '0);
   assign push         = in_if.valid && in_if.ready;
   assign pop          = out_if.valid && out_if.ready;

   always_ff @(posedge clock) begin
      if (reset || flush) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + PTR_W'(1);
         end
         if (push && !pop) begin
            count <= count + CNT_W'(1);
         end else if (pop && !push) begin
            count <= count - CNT_W'(1);
         end
      end
   end

   trans_pipe_stage_buf #(
      .WIDTH  (PAYLOAD_W),
      .DEPTH  (DEPTH),
      .ADDR_W (PTR_W)
   ) u_buf (
      .clock (clock),
      .we    (push),
      .waddr (wr_ptr),
      .wdata (in_if.payload),
      .raddr (rd_ptr),
      .rdata (head)
   );

   assign out_if.payload = out_if.valid ? head : NOP_PAYLOAD;
   assign occupancy      = count;

endmodule

// File: tb/tb_trans_pipe_stage.sv
// Bench for trans_pipe_stage: three instances (D2/pipe, D2/no-pipe, D3/pipe)
// share one stimulus stream; a scoreboard tracks the instance selected by sel.
module tb_trans_pipe_stage;
   import trans_pipe_stage_pkg::*;

   localparam int PW = DEFAULT_PAYLOAD_W;
   localparam logic [PW-1:0] NOP = PW'(64'h3C3C_0BAD_3C3C_0BAD);

   logic clock = 1'b0;
   logic reset = 1'b1;
   logic flush = 1'b0;
   logic in_valid = 1'b0;
   logic out_ready = 1'b0;
   logic [PW-1:0] in_payload = '0;

   int errors = 0;
   int checks = 0;
   int sel = 0;
   logic [PW-1:0] exp_q[$];

   always #5 clock = ~clock;

   trans_pipe_stage_if #(.W(PW)) a_in ();
   trans_pipe_stage_if #(.W(PW)) a_out ();
   trans_pipe_stage_if #(.W(PW)) b_in ();
   trans_pipe_stage_if #(.W(PW)) b_out ();
   trans_pipe_stage_if #(.W(PW)) c_in ();
   trans_pipe_stage_if #(.W(PW)) c_out ();
   logic [1:0] occ_a, occ_b, occ_c;

   assign a_in.valid = in_valid;  assign a_in.payload = in_payload;  assign a_out.ready = out_ready;
   assign b_in.valid = in_valid;  assign b_in.payload = in_payload;  assign b_out.ready = out_ready;
   assign c_in.valid = in_valid;  assign c_in.payload = in_payload;  assign c_out.ready = out_ready;

   trans_pipe_stage #(.PAYLOAD_W(PW), .DEPTH(2), .PIPE_READY(1), .NOP_PAYLOAD(NOP)) dut_a (
      .clock(clock), .reset(reset), .flush(flush), .in_if(a_in), .out_if(a_out), .occupancy(occ_a));
   trans_pipe_stage #(.PAYLOAD_W(PW), .DEPTH(2), .PIPE_READY(0), .NOP_PAYLOAD(NOP)) dut_b (
      .clock(clock), .reset(reset), .flush(flush), .in_if(b_in), .out_if(b_out), .occupancy(occ_b));
   trans_pipe_stage #(.PAYLOAD_W(PW), .DEPTH(3), .PIPE_READY(1), .NOP_PAYLOAD(NOP)) dut_c (
      .clock(clock), .reset(reset), .flush(flush), .in_if(c_in), .out_if(c_out), .occupancy(occ_c));

   logic [2:0]    obs_valid, obs_ready;
   logic [PW-1:0] obs_payload [3];
   logic [3:0]    obs_occ [3];
   assign obs_valid = {c_out.valid, b_out.valid, a_out.valid};
   assign obs_ready = {c_in.ready, b_in.ready, a_in.ready};
   assign obs_payload[0] = a_out.payload;
   assign obs_payload[1] = b_out.payload;
   assign obs_payload[2] = c_out.payload;
   assign obs_occ[0] = 4'(occ_a);
   assign obs_occ[1] = 4'(occ_b);
   assign obs_occ[2] = 4'(occ_c);

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   // Drive one cycle, compare the selected instance at negedge, update the model.
   task automatic cycle(input logic v, input logic [PW-1:0] p, input logic r);
      int dep;
      logic exp_valid, exp_ready;
      logic [PW-1:0] exp_pl;
      dep = (sel == 2) ? 3 : 2;
      in_valid = v; in_payload = p; out_ready = r;
      @(negedge clock);
      exp_valid = (exp_q.size() != 0);
      exp_ready = (exp_q.size() < dep) || ((sel != 1) && r);
      exp_pl = NOP;
      if (exp_valid) exp_pl = exp_q[0];
      checks++;
      if (obs_valid[sel] !== exp_valid) begin
         errors++; $display("FAIL out_valid dut%0d: got %b want %b", sel, obs_valid[sel], exp_valid);
      end
      checks++;
      if (obs_ready[sel] !== exp_ready) begin
         errors++; $display("FAIL in_ready dut%0d: got %b want %b", sel, obs_ready[sel], exp_ready);
      end
      checks++;
      if (obs_occ[sel] !== 4'(exp_q.size())) begin
         errors++; $display("FAIL occupancy dut%0d: got %0d want %0d", sel, obs_occ[sel], exp_q.size());
      end
      checks++;
      if (obs_payload[sel] !== exp_pl) begin
         errors++; $display("FAIL out_payload dut%0d: got %h want %h", sel, obs_payload[sel], exp_pl);
      end
      if (exp_valid && r) void'(exp_q.pop_front());
      if (v && exp_ready) exp_q.push_back(p);
   endtask

   task automatic step(input logic v, input logic [PW-1:0] p, input logic r);
      cycle(v, p, r);
      tick();
   endtask

   task automatic do_reset();
      reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
      tick();
      reset = 1'b0;
      exp_q.delete();
   endtask

   task automatic check_empty_all(input string tag);
      for (int k = 0; k < 3; k++) begin
         checks++;
         if (obs_valid[k] !== 1'b0 || obs_occ[k] !== 4'd0 || obs_payload[k] !== NOP) begin
            errors++;
            $display("FAIL %s dut%0d: valid=%b occ=%0d payload=%h want 0/0/%h",
                     tag, k, obs_valid[k], obs_occ[k], obs_payload[k], NOP);
         end
      end
   endtask

   task automatic test_reset();
      logic [PW-1:0] pat;
      pat = PW'({18{8'hA5}});
      reset = 1'b1; in_valid = 1'b1; in_payload = pat; out_ready = 1'b1;
      tick();
      for (int c = 0; c < 2; c++) begin
         @(negedge clock);
         check_empty_all("reset_state");
         checks++;
         if (obs_ready !== 3'b000) begin
            errors++; $display("FAIL reset_in_ready: got %b want 000", obs_ready);
         end
         tick();
      end
      reset = 1'b0; in_valid = 1'b0;
      sel = 0;
      exp_q.delete();
      step(1'b1, PW'(8'h5A), 1'b0);
      step(1'b0, '0, 1'b0);
      reset = 1'b1; in_valid = 1'b1;
      tick();
      @(negedge clock);
      check_empty_all("reset_midflight");
      reset = 1'b0; in_valid = 1'b0;
      exp_q.delete();
      tick();
   endtask

   task automatic test_streaming();
      do_reset();
      sel = 0;
      step(1'b1, PW'(8'h11), 1'b1);
      step(1'b1, PW'(8'h22), 1'b1);
      step(1'b1, PW'(8'h33), 1'b1);
      step(1'b0, '0, 1'b1);
      step(1'b0, '0, 1'b1);
   endtask

   task automatic test_backpressure();
      do_reset();
      sel = 0;
      step(1'b1, PW'(8'h11), 1'b0);
      step(1'b1, PW'(8'h22), 1'b0);
      cycle(1'b0, '0, 1'b0);
      checks++;
      if (b_in.ready !== 1'b0 || occ_b !== 2'd2) begin
         errors++; $display("FAIL bp_full_b: ready=%b occ=%0d want 0/2", b_in.ready, occ_b);
      end
      tick();
      cycle(1'b1, PW'(8'h33), 1'b1);
      checks++;
      if (b_in.ready !== 1'b0 || b_out.payload !== PW'(8'h11)) begin
         errors++; $display("FAIL bp_release_b: ready=%b payload=%h want 0/11", b_in.ready, b_out.payload);
      end
      tick();
      cycle(1'b0, '0, 1'b1);
      checks++;
      if (occ_b !== 2'd1 || b_out.payload !== PW'(8'h22)) begin
         errors++; $display("FAIL bp_drain_b: occ=%0d payload=%h want 1/22", occ_b, b_out.payload);
      end
      tick();
      step(1'b0, '0, 1'b1);
      step(1'b0, '0, 1'b1);
   endtask

   task automatic test_flush();
      do_reset();
      sel = 0;
      step(1'b1, PW'(8'h11), 1'b0);
      step(1'b1, PW'(8'h22), 1'b0);
      flush = 1'b1; in_valid = 1'b1; in_payload = PW'(8'h44); out_ready = 1'b0;
      @(negedge clock);
      checks++;
      if (obs_ready !== 3'b000) begin
         errors++; $display("FAIL flush_in_ready: got %b want 000", obs_ready);
      end
      tick();
      flush = 1'b0;
      exp_q.delete();
      step(1'b0, '0, 1'b1);
      step(1'b1, PW'(8'h55), 1'b1);
      step(1'b0, '0, 1'b1);
      step(1'b0, '0, 1'b1);
   endtask

   task automatic test_wrap();
      do_reset();
      sel = 2;
      for (int i = 0; i < 20; i++) begin
         step(1'($urandom_range(0, 3) != 0), PW'($urandom), 1'($urandom_range(0, 1)));
      end
      for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b1);
   endtask

   task automatic test_bubble();
      do_reset();
      sel = 0;
      for (int i = 0; i < 5; i++) begin
         cycle(1'b0, PW'($urandom), 1'b1);
         check_empty_all("bubble");
         tick();
      end
   endtask

   initial begin
      test_reset();
      test_streaming();
      test_backpressure();
      test_flush();
      test_wrap();
      test_bubble();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "timeout");
   end

endmodule
